// File: rtl/if_id_pipe_stage_pkg.sv
// Shared widths, NOP encoding and occupancy state encodings for the IF/ID stage.
package if_id_pipe_stage_pkg;
  localparam int unsigned IFID_PC_WIDTH       = 32;
  localparam int unsigned IFID_INST_WIDTH     = 32;
  localparam int unsigned IFID_REG_ADDR_WIDTH = 5;
  localparam logic [31:0] NOP_INST            = 32'h0000_0013;

  typedef enum logic [1:0] {
    IFID_EMPTY = 2'd0,
    IFID_FULL  = 2'd1,
    IFID_SKID  = 2'd2
  } ifid_state_e;
endpackage

// File: rtl/if_id_bundle_reg.sv
// One fetch bundle's PC/instruction/mask storage; masked lanes are stored as NOP.
module if_id_bundle_reg
  import if_id_pipe_stage_pkg::*;
#(
  parameter int LANES      = 1,
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_load,
  input  logic                        i_clear,
  input  logic [LANES*PC_WIDTH-1:0]   i_pc,
  input  logic [LANES*INST_WIDTH-1:0] i_inst,
  input  logic [LANES-1:0]            i_mask,
  output logic [LANES*PC_WIDTH-1:0]   o_pc,
  output logic [LANES*INST_WIDTH-1:0] o_inst,
  output logic [LANES-1:0]            o_mask
);
  logic [LANES*INST_WIDTH-1:0] w_inst_masked;
  logic [LANES*INST_WIDTH-1:0] r_inst;
  logic [LANES*PC_WIDTH-1:0]   r_pc;
  logic [LANES-1:0]            r_mask;

  // Lanes without a real instruction become NOP so decode never sees fetch garbage
  always_comb begin
    w_inst_masked = i_inst;
    for (int i = 0; i < LANES; i++) begin
      if (!i_mask[i]) begin
        w_inst_masked[i*INST_WIDTH +: INST_WIDTH] = INST_WIDTH'(NOP_INST);
      end else begin
        w_inst_masked[i*INST_WIDTH +: INST_WIDTH] = i_inst[i*INST_WIDTH +: INST_WIDTH];
      end
    end
  end

  // Clear (flush) keeps the PCs but kills every lane
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= '0;
      r_inst <= {LANES{INST_WIDTH'(NOP_INST)}};
      r_mask <= {LANES{1'b0}};
    end else if (i_clear) begin
      r_inst <= {LANES{INST_WIDTH'(NOP_INST)}};
      r_mask <= {LANES{1'b0}};
    end else if (i_load) begin
      r_pc   <= i_pc;
      r_inst <= w_inst_masked;
      r_mask <= i_mask;
    end
  end

  assign o_pc   = r_pc;
  assign o_inst = r_inst;
  assign o_mask = r_mask;
endmodule

// File: rtl/if_id_pipe_stage.sv
// IF/ID pipeline stage with valid/ready, flush and per-lane masking.
// Define IF_ID_SKID_EN to add a skid bundle and make in_ready a registered output.
module if_id_pipe_stage
  import if_id_pipe_stage_pkg::*;
#(
  parameter int PC_WIDTH       = IFID_PC_WIDTH,
  parameter int INST_WIDTH     = IFID_INST_WIDTH,
  parameter int REG_ADDR_WIDTH = IFID_REG_ADDR_WIDTH,
  parameter int LANES          = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LANES*PC_WIDTH-1:0]       in_pc,
  input  logic [LANES*INST_WIDTH-1:0]     in_inst,
  input  logic [LANES-1:0]                in_lane_mask,
  input  logic                            flush,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LANES*PC_WIDTH-1:0]       out_pc,
  output logic [LANES*INST_WIDTH-1:0]     out_inst,
  output logic [LANES-1:0]                out_lane_mask,
  output logic [LANES*7-1:0]              out_opcode,
  output logic [LANES*REG_ADDR_WIDTH-1:0] out_rs1,
  output logic [LANES*REG_ADDR_WIDTH-1:0] out_rs2,
  output logic [LANES*REG_ADDR_WIDTH-1:0] out_rd
);
  ifid_state_e                 r_state;
  ifid_state_e                 w_state_nxt;
  logic                        r_out_valid;
  logic                        w_accept;
  logic                        w_consume;
  logic                        w_main_load;
  logic [LANES*PC_WIDTH-1:0]   w_main_pc;
  logic [LANES*INST_WIDTH-1:0] w_main_inst;
  logic [LANES-1:0]            w_main_mask;

  assign w_accept  = in_valid & in_ready;
  assign w_consume = r_out_valid & out_ready;
  assign out_valid = r_out_valid;

`ifdef IF_ID_SKID_EN
  logic                        r_in_ready;
  logic                        w_skid_load;
  logic [LANES*PC_WIDTH-1:0]   w_skid_pc;
  logic [LANES*INST_WIDTH-1:0] w_skid_inst;
  logic [LANES-1:0]            w_skid_mask;

  assign in_ready = r_in_ready;

  // Occupancy transitions; flush empties the stage from any state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IFID_EMPTY: w_state_nxt = w_accept ? IFID_FULL : IFID_EMPTY;
      IFID_FULL: begin
        if (w_accept && !w_consume) begin
          w_state_nxt = IFID_SKID;
        end else if (!w_accept && w_consume) begin
          w_state_nxt = IFID_EMPTY;
        end else begin
          w_state_nxt = IFID_FULL;
        end
      end
      IFID_SKID:  w_state_nxt = w_consume ? IFID_FULL : IFID_SKID;
      default:    w_state_nxt = IFID_EMPTY;
    endcase
    if (flush) begin
      w_state_nxt = IFID_EMPTY;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  assign w_main_load = ~flush & (((r_state == IFID_EMPTY) & w_accept) |
                                 ((r_state == IFID_FULL) & w_accept & w_consume) |
                                 ((r_state == IFID_SKID) & w_consume));
  assign w_skid_load = ~flush & (r_state == IFID_FULL) & w_accept & ~w_consume;
  assign w_main_pc   = (r_state == IFID_SKID) ? w_skid_pc   : in_pc;
  assign w_main_inst = (r_state == IFID_SKID) ? w_skid_inst : in_inst;
  assign w_main_mask = (r_state == IFID_SKID) ? w_skid_mask : in_lane_mask;

  if_id_bundle_reg #(.LANES(LANES), .PC_WIDTH(PC_WIDTH), .INST_WIDTH(INST_WIDTH)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (flush),
    .i_pc    (in_pc),
    .i_inst  (in_inst),
    .i_mask  (in_lane_mask),
    .o_pc    (w_skid_pc),
    .o_inst  (w_skid_inst),
    .o_mask  (w_skid_mask)
  );

  // State plus handshake outputs decoded from the next state, so both are registered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IFID_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != IFID_EMPTY);
      r_in_ready  <= (w_state_nxt != IFID_SKID);
    end
  end
`else
  assign in_ready = ~r_out_valid | out_ready;

  // Single-register occupancy; an accept always lands in the main register
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IFID_EMPTY: w_state_nxt = w_accept ? IFID_FULL : IFID_EMPTY;
      IFID_FULL:  w_state_nxt = (w_accept || !w_consume) ? IFID_FULL : IFID_EMPTY;
      default:    w_state_nxt = IFID_EMPTY;
    endcase
    if (flush) begin
      w_state_nxt = IFID_EMPTY;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  assign w_main_load = w_accept & ~flush;
  assign w_main_pc   = in_pc;
  assign w_main_inst = in_inst;
  assign w_main_mask = in_lane_mask;

  // State and registered out_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IFID_EMPTY;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != IFID_EMPTY);
    end
  end
`endif

  if_id_bundle_reg #(.LANES(LANES), .PC_WIDTH(PC_WIDTH), .INST_WIDTH(INST_WIDTH)) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_main_load),
    .i_clear (flush),
    .i_pc    (w_main_pc),
    .i_inst  (w_main_inst),
    .i_mask  (w_main_mask),
    .o_pc    (out_pc),
    .o_inst  (out_inst),
    .o_mask  (out_lane_mask)
  );

  for (genvar g = 0; g < LANES; g++) begin : g_fields
    assign out_opcode[g*7 +: 7]                    = out_inst[g*INST_WIDTH +: 7];
    assign out_rd[g*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]  = out_inst[g*INST_WIDTH + 7  +: REG_ADDR_WIDTH];
    assign out_rs1[g*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] = out_inst[g*INST_WIDTH + 15 +: REG_ADDR_WIDTH];
    assign out_rs2[g*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] = out_inst[g*INST_WIDTH + 20 +: REG_ADDR_WIDTH];
  end
endmodule
